// File: rtl/life_grid_engine_if.sv
// life_grid_engine_if: plot request stream from the Life engine to the pixel writer
interface life_grid_engine_if #(parameter int COORD_W = 8);
  logic plot_valid;
  logic plot_ready;
  logic [COORD_W-1:0] plot_x;
  logic [COORD_W-1:0] plot_y;
  logic [2:0] plot_colour;
  modport master(output plot_valid, plot_x, plot_y, plot_colour, input plot_ready);
  modport slave(input plot_valid, plot_x, plot_y, plot_colour, output plot_ready);
endinterface

// File: rtl/life_grid_engine.sv
// life_grid_engine: Conway's Life grid with load/clear/step commands and a changed-cell plot stream
module life_grid_engine #(
  parameter int GRID_W = 16,
  parameter int GRID_H = 16,
  parameter int COORD_W = 8,
  parameter bit WRAP = 1'b0,
  parameter logic [2:0] COLOUR_ALIVE = 3'b111,
  localparam int N = GRID_W * GRID_H,
  localparam int IW = $clog2(N),
  localparam int AW = $clog2(N + 1)
) (
  input  logic clock,
  input  logic reset_n,
  input  logic cmd_clear,
  input  logic cmd_load,
  input  logic cmd_step,
  input  logic [COORD_W-1:0] x_in,
  input  logic [COORD_W-1:0] y_in,
  input  logic cell_val,
  output logic busy,
  output logic done,
  output logic stable,
  output logic [15:0] gen_count,
  output logic [AW-1:0] alive_count,
  life_grid_engine_if.master plot
);
  typedef enum logic [2:0] {IDLE, LOAD_PLOT, SCAN, COMMIT, CLEAR} state_t;
  state_t state, state_d;
  logic [N-1:0] cur, nxt;
  logic [COORD_W-1:0] x, y, lx, ly;
  logic [AW-1:0] acc;
  logic [IW-1:0] ci, li;
  logic [3:0] cnt;
  logic lval, chg, adv, last, alive, nv, changed, in_range;
  int nx, ny;

  assign in_range = int'(x_in) < GRID_W && int'(y_in) < GRID_H;
  assign ci = IW'(int'(y) * GRID_W + int'(x));
  assign li = IW'(int'(y_in) * GRID_W + int'(x_in));
  assign last = int'(x) == GRID_W - 1 && int'(y) == GRID_H - 1;
  assign alive = cur[ci];
  assign nv = cnt == 4'd3 || (alive && cnt == 4'd2);
  assign changed = nv ^ alive;

  // neighbour count of the scan cell on the pre-step grid; off-grid cells are dead unless edges wrap
  always_comb begin
    cnt = '0;
    nx = 0;
    ny = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++) begin
        nx = int'(x) + dx;
        ny = int'(y) + dy;
        if (WRAP) begin
          nx = nx < 0 ? nx + GRID_W : nx >= GRID_W ? nx - GRID_W : nx;
          ny = ny < 0 ? ny + GRID_H : ny >= GRID_H ? ny - GRID_H : ny;
        end
        if ((dx != 0 || dy != 0) && nx >= 0 && nx < GRID_W && ny >= 0 && ny < GRID_H)
          cnt = cnt + 4'(cur[IW'(ny * GRID_W + nx)]);
      end
  end

  // next state, plot request and status strobes
  always_comb begin
    state_d = state;
    busy = state != IDLE;
    done = 1'b0;
    adv = 1'b0;
    plot.plot_valid = 1'b0;
    plot.plot_x = x;
    plot.plot_y = y;
    plot.plot_colour = 3'b000;
    case (state)
      IDLE: begin
        if (cmd_clear) state_d = CLEAR;
        else if (cmd_load) state_d = in_range ? LOAD_PLOT : IDLE;
        else if (cmd_step) state_d = SCAN;
      end
      LOAD_PLOT: begin
        plot.plot_valid = 1'b1;
        plot.plot_x = lx;
        plot.plot_y = ly;
        plot.plot_colour = lval ? COLOUR_ALIVE : 3'b000;
        if (plot.plot_ready) state_d = IDLE;
      end
      SCAN: begin
        plot.plot_valid = changed;
        plot.plot_colour = nv ? COLOUR_ALIVE : 3'b000;
        adv = !changed || plot.plot_ready;
        if (adv && last) state_d = COMMIT;
      end
      COMMIT: begin
        done = 1'b1;
        state_d = IDLE;
      end
      CLEAR: begin
        plot.plot_valid = alive;
        adv = !alive || plot.plot_ready;
        done = adv && last;
        if (adv && last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_d;

  // grid storage, raster walker and counters
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur <= '0;
      nxt <= '0;
      x <= '0;
      y <= '0;
      lx <= '0;
      ly <= '0;
      lval <= 1'b0;
      acc <= '0;
      chg <= 1'b0;
      stable <= 1'b0;
      gen_count <= '0;
      alive_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          x <= '0;
          y <= '0;
          acc <= '0;
          chg <= 1'b0;
          if (!cmd_clear && cmd_load && in_range) begin
            cur[li] <= cell_val;
            if (cell_val != cur[li]) alive_count <= cell_val ? alive_count + AW'(1) : alive_count - AW'(1);
            lx <= x_in;
            ly <= y_in;
            lval <= cell_val;
          end
        end
        SCAN:
          if (adv) begin
            nxt[ci] <= nv;
            acc <= acc + AW'(nv);
            chg <= chg | changed;
            if (!last) begin
              x <= int'(x) == GRID_W - 1 ? '0 : x + COORD_W'(1);
              y <= int'(x) == GRID_W - 1 ? y + COORD_W'(1) : y;
            end
          end
        COMMIT: begin
          cur <= nxt;
          gen_count <= gen_count + 16'd1;
          alive_count <= acc;
          stable <= !chg;
        end
        CLEAR:
          if (adv) begin
            if (last) begin
              cur <= '0;
              alive_count <= '0;
            end else begin
              x <= int'(x) == GRID_W - 1 ? '0 : x + COORD_W'(1);
              y <= int'(x) == GRID_W - 1 ? y + COORD_W'(1) : y;
            end
          end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_life_grid_engine.sv
// tb_life_grid_engine: checks two 5x5 engines (edges dead / edges wrapped) against a grid model
module tb_life_grid_engine;
  localparam int W = 5;
  localparam int H = 5;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic cmd_clear = 1'b0, cmd_load = 1'b0, cmd_step = 1'b0, cell_val = 1'b0;
  logic [7:0] x_in = '0, y_in = '0;
  logic busy0, done0, stable0, busy1, done1, stable1;
  logic [15:0] gen0, gen1;
  logic [4:0] alive0, alive1;

  life_grid_engine_if #(.COORD_W(8)) p0 ();
  life_grid_engine_if #(.COORD_W(8)) p1 ();

  life_grid_engine #(.GRID_W(W), .GRID_H(H), .COORD_W(8), .WRAP(1'b0), .COLOUR_ALIVE(3'b111)) dut0 (
    .clock(clock), .reset_n(reset_n), .cmd_clear(cmd_clear), .cmd_load(cmd_load), .cmd_step(cmd_step),
    .x_in(x_in), .y_in(y_in), .cell_val(cell_val), .busy(busy0), .done(done0), .stable(stable0),
    .gen_count(gen0), .alive_count(alive0), .plot(p0));

  life_grid_engine #(.GRID_W(W), .GRID_H(H), .COORD_W(8), .WRAP(1'b1), .COLOUR_ALIVE(3'b111)) dut1 (
    .clock(clock), .reset_n(reset_n), .cmd_clear(cmd_clear), .cmd_load(cmd_load), .cmd_step(cmd_step),
    .x_in(x_in), .y_in(y_in), .cell_val(cell_val), .busy(busy1), .done(done1), .stable(stable1),
    .gen_count(gen1), .alive_count(alive1), .plot(p1));

  always #5 clock = ~clock;

  int tests = 0, fails = 0;
  logic [18:0] q0[$], q1[$], e0[$], e1[$];
  int rp0 = 0, rp1 = 0, np0 = 0;
  int dn0 = 0, dn1 = 0, edn = 0, hs_bad = 0;
  logic pend0 = 1'b0, pend1 = 1'b0;
  logic [18:0] hold0 = '0, hold1 = '0;
  bit mg [2][H][W];
  bit mst [2];
  int mgen = 0;
  bit rnd = 1'b0;

  // records accepted plots, done pulses and any request that changes before it is accepted
  always @(negedge clock) begin
    logic [18:0] c0, c1;
    c0 = {p0.plot_x, p0.plot_y, p0.plot_colour};
    c1 = {p1.plot_x, p1.plot_y, p1.plot_colour};
    if (reset_n && pend0 && (!p0.plot_valid || c0 != hold0)) hs_bad++;
    if (reset_n && pend1 && (!p1.plot_valid || c1 != hold1)) hs_bad++;
    if (p0.plot_valid && p0.plot_ready) begin q0.push_back(c0); pend0 = 1'b0; end
    else begin pend0 = p0.plot_valid; hold0 = c0; end
    if (p1.plot_valid && p1.plot_ready) begin q1.push_back(c1); pend1 = 1'b0; end
    else begin pend1 = p1.plot_valid; hold1 = c1; end
    dn0 += int'(done0);
    dn1 += int'(done1);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input longint got, input longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic cmp_q(input string nm, input logic [18:0] got[$], input int from, input logic [18:0] ex[$]);
    chk($sformatf("%s count", nm), got.size() - from, ex.size());
    for (int i = 0; i < ex.size() && from + i < got.size(); i++)
      chk($sformatf("%s[%0d] xyc", nm, i), got[from + i], ex[i]);
  endtask

  task automatic push(input int d, input int x, input int y, input bit a);
    logic [18:0] p;
    p = {8'(x), 8'(y), a ? 3'd7 : 3'd0};
    if (d == 0) e0.push_back(p); else e1.push_back(p);
  endtask

  function automatic int m_alive(input int d);
    int s = 0;
    for (int j = 0; j < H; j++) for (int i = 0; i < W; i++) s += int'(mg[d][j][i]);
    return s;
  endfunction

  task automatic m_step(input int d);
    bit n [H][W];
    bit ch = 1'b0;
    for (int j = 0; j < H; j++)
      for (int i = 0; i < W; i++) begin
        int c = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if (dx != 0 || dy != 0) begin
              int xx = i + dx, yy = j + dy;
              if (d == 1) begin xx = (xx + W) % W; yy = (yy + H) % H; end
              if (xx >= 0 && xx < W && yy >= 0 && yy < H) c += int'(mg[d][yy][xx]);
            end
        n[j][i] = c == 3 || (mg[d][j][i] && c == 2);
        if (n[j][i] != mg[d][j][i]) begin ch = 1'b1; push(d, i, j, n[j][i]); end
      end
    for (int j = 0; j < H; j++) for (int i = 0; i < W; i++) mg[d][j][i] = n[j][i];
    mst[d] = !ch;
  endtask

  task automatic model(input int op, input int x, input int y, input int v);
    for (int d = 0; d < 2; d++) begin
      if (op == 1) begin
        for (int j = 0; j < H; j++)
          for (int i = 0; i < W; i++)
            if (mg[d][j][i]) begin push(d, i, j, 1'b0); mg[d][j][i] = 1'b0; end
      end else if (op == 2) begin
        if (x < W && y < H) begin mg[d][y][x] = v[0]; push(d, x, y, v[0]); end
      end else if (op == 3) m_step(d);
    end
    if (op == 1 || op == 3) edn++;
    if (op == 3) mgen++;
  endtask

  task automatic issue(input int op, input int x, input int y, input int v);
    model(op, x, y, v);
    cmd_clear = op == 1;
    cmd_load = op == 2;
    cmd_step = op == 3;
    x_in = 8'(x);
    y_in = 8'(y);
    cell_val = v[0];
    @(posedge clock); #1;
    cmd_clear = 1'b0;
    cmd_load = 1'b0;
    cmd_step = 1'b0;
  endtask

  task automatic finish();
    int n = 0;
    while ((busy0 || busy1) && n < 3000) begin
      if (rnd) begin
        p0.plot_ready = $urandom_range(0, 3) != 0;
        p1.plot_ready = $urandom_range(0, 3) != 0;
      end
      @(posedge clock); #1;
      n++;
    end
    chk("busy timeout", int'(n < 3000), 1);
    np0 = q0.size() - rp0;
    cmp_q("plots0", q0, rp0, e0);
    cmp_q("plots1", q1, rp1, e1);
    rp0 = q0.size();
    rp1 = q1.size();
    e0.delete();
    e1.delete();
    chk("alive0", alive0, m_alive(0));
    chk("alive1", alive1, m_alive(1));
    chk("gen0", gen0, mgen % 65536);
    chk("gen1", gen1, mgen % 65536);
    chk("stable0", stable0, mst[0]);
    chk("stable1", stable1, mst[1]);
    chk("done pulses0", dn0, edn);
    chk("done pulses1", dn1, edn);
    chk("handshake hold", hs_bad, 0);
  endtask

  task automatic blinker();
    issue(1, 0, 0, 0); finish();
    issue(2, 1, 1, 1); finish();
    issue(2, 2, 1, 1); finish();
    issue(2, 3, 1, 1); finish();
  endtask

  typedef struct {
    int op; int x; int y; int v;
    int np; int al0; int al1; int gen; int st;
  } vec_t;
  vec_t tv [20];

  initial begin
    int k;
    tv[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[1]  = '{2, 1, 1, 1, 1, 1, 1, 0, 0};
    tv[2]  = '{2, 2, 1, 1, 1, 2, 2, 0, 0};
    tv[3]  = '{2, 3, 1, 1, 1, 3, 3, 0, 0};
    tv[4]  = '{3, 0, 0, 0, 4, 3, 3, 1, 0};
    tv[5]  = '{3, 0, 0, 0, 4, 3, 3, 2, 0};
    tv[6]  = '{2, 5, 0, 1, 0, 3, 3, 2, 0};
    tv[7]  = '{1, 0, 0, 0, 3, 0, 0, 2, 0};
    tv[8]  = '{2, 1, 1, 1, 1, 1, 1, 2, 0};
    tv[9]  = '{2, 2, 1, 1, 1, 2, 2, 2, 0};
    tv[10] = '{2, 1, 2, 1, 1, 3, 3, 2, 0};
    tv[11] = '{2, 2, 2, 1, 1, 4, 4, 2, 0};
    tv[12] = '{3, 0, 0, 0, 0, 4, 4, 3, 1};
    tv[13] = '{2, 2, 2, 1, 1, 4, 4, 3, 1};
    tv[14] = '{2, 2, 2, 0, 1, 3, 3, 3, 1};
    tv[15] = '{1, 0, 0, 0, 3, 0, 0, 3, 1};
    tv[16] = '{2, 4, 2, 1, 1, 1, 1, 3, 1};
    tv[17] = '{2, 0, 2, 1, 1, 2, 2, 3, 1};
    tv[18] = '{2, 1, 2, 1, 1, 3, 3, 3, 1};
    tv[19] = '{3, 0, 0, 0, 3, 0, 3, 4, 0};
    p0.plot_ready = 1'b1;
    p1.plot_ready = 1'b1;
    #1;
    chk("reset outputs0", {p0.plot_valid, busy0, done0, stable0, gen0, alive0, p0.plot_x, p0.plot_y, p0.plot_colour}, 0);
    chk("reset outputs1", {p1.plot_valid, busy1, done1, stable1, gen1, alive1, p1.plot_x, p1.plot_y, p1.plot_colour}, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 20; i++) begin
      issue(tv[i].op, tv[i].x, tv[i].y, tv[i].v);
      finish();
      chk($sformatf("vec%0d plots0", i), np0, tv[i].np);
      chk($sformatf("vec%0d alive0", i), alive0, tv[i].al0);
      chk($sformatf("vec%0d alive1", i), alive1, tv[i].al1);
      chk($sformatf("vec%0d gen0", i), gen0, tv[i].gen);
      chk($sformatf("vec%0d stable0", i), stable0, tv[i].st);
    end

    blinker();
    issue(3, 0, 0, 0);
    k = 1;
    while (!done0 && k < 100) begin @(posedge clock); #1; k++; end
    chk("step done cycle", k, 26);
    @(posedge clock); #1;
    chk("busy after commit", busy0, 0);
    finish();

    issue(3, 0, 0, 0); finish();
    issue(3, 0, 0, 0);
    k = 1;
    while (!p0.plot_valid && k < 50) begin @(posedge clock); #1; k++; end
    chk("first request cycle", k, 3);
    p0.plot_ready = 1'b0;
    p1.plot_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("stall hold %0d", i), {p0.plot_valid, p0.plot_x, p0.plot_y, p0.plot_colour}, {1'b1, 8'd2, 8'd0, 3'd7});
      @(posedge clock); #1;
      k++;
    end
    p0.plot_ready = 1'b1;
    p1.plot_ready = 1'b1;
    while (!done0 && k < 100) begin @(posedge clock); #1; k++; end
    chk("stalled step done cycle", k, 36);
    finish();

    issue(3, 0, 0, 0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    cmd_step = 1'b1; cmd_load = 1'b1; x_in = 8'd0; y_in = 8'd0; cell_val = 1'b1;
    @(posedge clock); #1;
    cmd_step = 1'b0; cmd_load = 1'b0;
    finish();

    rnd = 1'b1;
    for (int i = 0; i < 40; i++) begin
      int r = $urandom_range(0, 9);
      if (r < 6) issue(2, $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 1));
      else if (r < 9) issue(3, 0, 0, 0);
      else issue(1, 0, 0, 0);
      finish();
    end
    rnd = 1'b0;
    p0.plot_ready = 1'b1;
    p1.plot_ready = 1'b1;
    @(posedge clock); #1;

    blinker();
    p0.plot_ready = 1'b0;
    p1.plot_ready = 1'b0;
    cmd_step = 1'b1;
    @(posedge clock); #1;
    cmd_step = 1'b0;
    k = 1;
    while (!p0.plot_valid && k < 50) begin @(posedge clock); #1; k++; end
    chk("scan request before reset", p0.plot_valid, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("async reset valid0", p0.plot_valid, 0);
    chk("async reset valid1", p1.plot_valid, 0);
    chk("async reset busy0", busy0, 0);
    chk("async reset gen0", gen0, 0);
    chk("async reset alive0", alive0, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      mst[d] = 1'b0;
      for (int j = 0; j < H; j++) for (int i = 0; i < W; i++) mg[d][j][i] = 1'b0;
    end
    mgen = 0;
    p0.plot_ready = 1'b1;
    p1.plot_ready = 1'b1;
    @(posedge clock); #1;
    issue(2, 2, 2, 1);
    finish();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/life_grid_engine.md
# life_grid_engine

Parametrised Conway's Life engine: holds a GRID_W x GRID_H cell array, accepts cell loads and clear/step commands from the control FSM, and emits one plot request per changed cell to the VGA adapter through a valid/ready handshake. It replaces the fixed 4x4 simulation block with a configurable grid, optional toroidal wrap, a stall-safe pixel stream, and generation/population status.

## Interface
- GRID_W, 16, grid width in cells (3..160)
- GRID_H, 16, grid height in cells (3..120)
- COORD_W, 8, coordinate width; 2^COORD_W >= max(GRID_W, GRID_H)
- WRAP, 0, 0 = off-grid neighbours are dead; 1 = toroidal edges
- COLOUR_ALIVE, 3'b111, plot colour for a live cell; dead plots 3'b000
- clock  in  1  system clock; the only clock
- reset_n  in  1  asynchronous, active-low reset
- cmd_clear  in  1  kill all cells; sampled in IDLE only
- cmd_load  in  1  write cell_val at (x_in, y_in); sampled in IDLE only
- cmd_step  in  1  compute one generation; sampled in IDLE only
- x_in, y_in  in  COORD_W  load coordinates
- cell_val  in  1  value to load
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at the end of step or clear
- stable  out  1  last step changed no cell
- plot_valid  out  1  plot request pending
- plot_ready  in  1  downstream accepts the request
- plot_x, plot_y  out  COORD_W  pixel coordinates
- plot_colour  out  3  pixel colour
- gen_count  out  16  generations completed; wraps 65535 -> 0
- alive_count  out  clog2(GRID_W*GRID_H+1)  live cell count

## Operation
- Storage: two bit arrays, cur and nxt, each GRID_W*GRID_H bits, indexed y*GRID_W+x.
- States: IDLE, LOAD_PLOT, SCAN, COMMIT, CLEAR.
- IDLE priority for simultaneous commands: clear > load > step. All commands are ignored while busy.
- Load: if x_in < GRID_W and y_in < GRID_H, then write cur[x_in,y_in] = cell_val and adjust alive_count by +1/-1 or 0. Then go to LOAD_PLOT and present (x_in, y_in) with colour cell_val ? COLOUR_ALIVE : 0, even when the value is unchanged. Return to IDLE on handshake. Out-of-range loads are dropped: no write, no plot, stay in IDLE.
- Step: SCAN walks the index 0..W*H-1 in raster order (x fastest).
  - For each cell, count the 8 neighbours in cur (0..8, 4-bit), respecting WRAP.
  - Next state: alive iff count==3, or (alive and count==2). Write it to nxt.
  - Unchanged cell: advance the index next cycle.
  - Changed cell: assert plot_valid with the cell's coordinates and new colour; advance only on plot_valid & plot_ready.
  - After the last cell: COMMIT (cur <= nxt, gen_count += 1, alive_count <= live total accumulated during SCAN, stable <= no changes seen, done = 1), then IDLE.
- Clear: walk the raster. Each live cell is plotted with colour 0 and handshaken; dead cells take one cycle. On the last cell: cur cleared, alive_count = 0, done = 1, then IDLE. gen_count and stable are unchanged.
- Handshake: once plot_valid rises, it and plot_x/plot_y/plot_colour hold stable until plot_ready is sampled high. A request is accepted on a cycle with plot_valid & plot_ready.

## Timing
- Reset values: every output 0; cur, nxt, gen_count, alive_count 0; state IDLE.
- Reset is asynchronous: asserting reset_n low mid-SCAN drops plot_valid immediately and discards the pending plot. The displayed image is not cleared by this block.
- Command sampled at edge N → busy high from N+1.
- Load with plot_ready held high: plot_valid high for 1 cycle; busy high for 1 cycle.
- Step with plot_ready held high: W*H SCAN cycles + 1 COMMIT cycle. done coincides with COMMIT; busy falls the following cycle.
- Each cycle plot_ready is low while plot_valid is high adds exactly 1 cycle.
- At most one plot is accepted per cycle. Plots appear in strict raster order.
- Changes in cur become visible only at COMMIT; the whole generation is evaluated on the pre-step grid.

## Test plan
- 5x5, WRAP=0, ready=1: load (1,1), (2,1), (3,1) → three white plots, alive_count=3. Step → plots in order: (2,0) white, (1,1) black, (3,1) black, (2,2) white. done 26 cycles after step, gen_count=1, alive_count=3, stable=0.
- 5x5: load 2x2 block at (1,1)-(2,2), then step → no plot_valid, done after 26 cycles, stable=1, gen_count=1.
- Blinker step with plot_ready low for 10 cycles at the first request → plot_valid and (2,0, white) held for those 10 cycles; done at cycle 36.
- Load (4,2), (0,2), (1,2), then step. WRAP=1 → vertical blinker at x=0, rows 1..3. WRAP=0 → three black plots, alive_count=0.
- Load x_in=5 on 5x5 → no plot, no state change. cmd_step while busy → ignored. cmd_clear with 3 live cells → exactly 3 black plots, alive_count=0, done pulses once.
- Assert reset_n low mid-SCAN with plot_valid high → plot_valid, busy, gen_count and alive_count read 0 before the next clock edge.
